// File: rtl/multiplicador_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier controller.
// Drives an external somador adder via add_* ports; one add per RUN cycle.
module multiplicador_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_ci,
  output logic                 add_mode,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_co
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last;
  logic [2*WIDTH:0]   acc_sum;
  logic [2*WIDTH-1:0] acc_shift;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last     = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign add_a    = acc_hi;
  assign add_b    = mcand;
  assign add_ci   = 1'b0;
  assign add_mode = 1'b0;

  // Sum is formed one bit wider so the adder carry survives the right shift.
  always_comb begin
    acc_sum   = '0;
    if (acc_lo[0]) acc_sum = {add_co, add_s, acc_lo};
    else           acc_sum = {1'b0, acc_hi, acc_lo};
    acc_shift = acc_sum[2*WIDTH:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= x;
      acc_lo <= y;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      {acc_hi, acc_lo} <= acc_shift;
      cnt              <= cnt + 1'b1;
      if (last) product <= acc_shift;
    end
  end

endmodule
